// File: rtl/mure_pkg.sv
// mure_pkg: shared types for the connector FIFOs and the uop reader that drains them.
package mure_pkg;
    localparam int XLEN          = 32;
    localparam int INST_LEN      = 32;
    localparam int CAUSE_LEN     = 5;
    localparam int PRIV_LEN      = 2;
    localparam int ITYPE_LEN     = 3;
    localparam int ILASTSIZE_LEN = 2;

    typedef enum logic [ITYPE_LEN-1:0] {
        IT_STD  = 3'd0,
        IT_EXC  = 3'd1,
        IT_INT  = 3'd2,
        IT_ERET = 3'd3,
        IT_NTB  = 3'd4,
        IT_TB   = 3'd5,
        IT_UJ   = 3'd6
    } itype_e;

    typedef struct packed {
        itype_e                   itype;
        logic                     iretire;
        logic [ILASTSIZE_LEN-1:0] ilastsize;
        logic [INST_LEN-1:0]      iaddr;
    } uop_entry_s;

    typedef struct packed {
        logic [CAUSE_LEN-1:0] cause;
        logic [XLEN-1:0]      tval;
        logic [PRIV_LEN-1:0]  priv;
    } common_entry_s;

    typedef enum logic [1:0] {IDLE, ACC, WAIT_CMN, HOLD} reader_state_e;

    function automatic logic needs_common(itype_e t);
        return t inside {IT_EXC, IT_INT, IT_ERET};
    endfunction

    function automatic logic has_cause(itype_e t);
        return t == IT_EXC || t == IT_INT;
    endfunction
endpackage

// File: rtl/mure_uop_reader.sv
// mure_uop_reader: drains the uop/common FIFOs, coalescing retired STD uops into
// instruction blocks presented one at a time on a valid/ready port.
module mure_uop_reader
    import mure_pkg::*;
#(
    parameter int                  IRETIRE_LEN  = 7,
    parameter int                  MAX_IRETIRE  = 64,
    parameter int                  FLUSH_CYCLES = 8,
    parameter logic [PRIV_LEN-1:0] PRIV_RESET   = 2'b11
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     uop_empty_i,
    input  uop_entry_s               uop_entry_i,
    output logic                     uop_pop_o,
    input  logic                     cmn_empty_i,
    input  common_entry_s            cmn_entry_i,
    output logic                     cmn_pop_o,
    output logic                     valid_o,
    input  logic                     ready_i,
    output logic [ITYPE_LEN-1:0]     itype_o,
    output logic [CAUSE_LEN-1:0]     cause_o,
    output logic [XLEN-1:0]          tval_o,
    output logic [PRIV_LEN-1:0]      priv_o,
    output logic [INST_LEN-1:0]      iaddr_o,
    output logic [IRETIRE_LEN-1:0]   iretire_o,
    output logic [ILASTSIZE_LEN-1:0] ilastsize_o
);
    localparam int CW = $clog2(FLUSH_CYCLES + 1);
    localparam int SW = IRETIRE_LEN + 1;

    reader_state_e state;
    logic [CW-1:0] cnt;
    logic [SW-1:0] base, add, sum;
    logic hv, nc, std_ret, fits, ok, drop, acc_std, merge, to_wait, close;

    // base is the halfword count already in the block; zero means the uop starts a new block
    always_comb begin
        hv = !uop_empty_i;
        nc = needs_common(uop_entry_i.itype);
        base = (state == IDLE) ? '0 : {1'b0, iretire_o};
        add = uop_entry_i.iretire ? SW'(1) << uop_entry_i.ilastsize : '0;
        sum = base + add;
        fits = sum <= SW'(MAX_IRETIRE);
        std_ret = hv && uop_entry_i.iretire && uop_entry_i.itype == IT_STD;
        ok = (state == IDLE || state == ACC) && fits;
        drop = ok && hv && !uop_entry_i.iretire && !nc;
        acc_std = ok && std_ret;
        merge = (ok && hv && (nc ? !cmn_empty_i : uop_entry_i.iretire && uop_entry_i.itype != IT_STD))
             || (state == WAIT_CMN && hv && !cmn_empty_i);
        to_wait = ok && hv && nc && cmn_empty_i;
        close = state == ACC && (hv ? !fits : cnt == CW'(FLUSH_CYCLES - 1));
        uop_pop_o = !rst_i && (drop || acc_std || merge);
        cmn_pop_o = !rst_i && merge && nc;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
            valid_o <= 1'b0;
            cnt <= '0;
            itype_o <= '0;
            cause_o <= '0;
            tval_o <= '0;
            priv_o <= PRIV_RESET;
            iaddr_o <= '0;
            iretire_o <= '0;
            ilastsize_o <= '0;
        end else if (acc_std) begin
            state <= ACC;
            cnt <= '0;
            itype_o <= IT_STD;
            cause_o <= '0;
            tval_o <= '0;
            iaddr_o <= (base == '0) ? uop_entry_i.iaddr : iaddr_o;
            iretire_o <= sum[IRETIRE_LEN-1:0];
            ilastsize_o <= uop_entry_i.ilastsize;
        end else if (merge) begin
            state <= HOLD;
            valid_o <= 1'b1;
            cnt <= '0;
            itype_o <= uop_entry_i.itype;
            cause_o <= has_cause(uop_entry_i.itype) ? cmn_entry_i.cause : '0;
            tval_o <= has_cause(uop_entry_i.itype) ? cmn_entry_i.tval : '0;
            priv_o <= nc ? cmn_entry_i.priv : priv_o;
            iaddr_o <= (base == '0) ? uop_entry_i.iaddr : iaddr_o;
            iretire_o <= sum[IRETIRE_LEN-1:0];
            ilastsize_o <= uop_entry_i.ilastsize;
        end else if (to_wait) begin
            state <= WAIT_CMN;
            cnt <= '0;
            iretire_o <= base[IRETIRE_LEN-1:0];
        end else if (close) begin
            state <= HOLD;
            valid_o <= 1'b1;
            cnt <= '0;
            itype_o <= IT_STD;
        end else if (state == ACC && !hv) begin
            cnt <= cnt + 1'b1;
        end else if (state == HOLD && ready_i) begin
            state <= IDLE;
            valid_o <= 1'b0;
        end
    end
endmodule
